// File: rtl/cobs_encoder_pkg.sv
// Shared constants, state encoding and sizing helper for the COBS encoder.
package cobs_encoder_pkg;

  localparam logic [7:0] COBS_SENTINEL        = 8'h00;
  localparam logic [7:0] COBS_TAIL_CODE       = 8'h01;
  localparam int         COBS_MAX_RUN_DEFAULT = 254;

  typedef logic [1:0] cobs_state_t;

  localparam cobs_state_t S_FILL = 2'd0;
  localparam cobs_state_t S_CODE = 2'd1;
  localparam cobs_state_t S_DATA = 2'd2;
  localparam cobs_state_t S_TAIL = 2'd3;

  // Address width for a block buffer holding max_run bytes (at least one bit).
  function automatic int buf_addr_width(input int max_run);
    if (max_run > 1) begin
      return $clog2(max_run);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cobs_block_buffer.sv
// Holds one COBS block of non-zero bytes: one write port, one asynchronous read port.
// Contents are not reset; a block is always written before it is read.
module cobs_block_buffer
  import cobs_encoder_pkg::*;
#(
  parameter int DEPTH = COBS_MAX_RUN_DEFAULT,
  parameter int AW    = buf_addr_width(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  // Store an accepted non-zero input byte at its position within the block.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/cobs_encoder.sv
// COBS encoder: gathers a run of non-zero bytes, then emits code byte plus run.
// A packet ending in 0x00 gets a final empty block (0x01). All outputs decode
// from registered state, so there is no combinational input-to-output path.
module cobs_encoder
  import cobs_encoder_pkg::*;
#(
  parameter int MAX_RUN = COBS_MAX_RUN_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam int AW = buf_addr_width(MAX_RUN);
  localparam int CW = $clog2(MAX_RUN + 1);
  localparam logic [CW-1:0] RUN_FULL = CW'(MAX_RUN);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};

  cobs_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          end_pkt_q, end_pkt_d;
  logic          tail_q, tail_d;

  logic          buf_wr_en_s;
  logic [7:0]    buf_rd_data_s;
  logic [CW-1:0] count_inc_s;
  logic          last_idx_s;

  assign count_inc_s = count_q + CW'(1);
  assign last_idx_s  = (CW'(rd_idx_q) == (count_q - CW'(1)));

  cobs_block_buffer #(
    .DEPTH (MAX_RUN),
    .AW    (AW)
  ) u_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en_s),
    .wr_addr (AW'(count_q)),
    .wr_data (in_data),
    .rd_addr (rd_idx_q),
    .rd_data (buf_rd_data_s)
  );

  // State and block bookkeeping registers; reset discards any partial block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FILL;
      count_q   <= CNT_ZERO;
      rd_idx_q  <= IDX_ZERO;
      end_pkt_q <= 1'b0;
      tail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_idx_q  <= rd_idx_d;
      end_pkt_q <= end_pkt_d;
      tail_q    <= tail_d;
    end
  end

  // Next-state and datapath update: fill a block, then drain code and bytes.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    end_pkt_d   = end_pkt_q;
    tail_d      = tail_q;
    buf_wr_en_s = 1'b0;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          if (in_data != COBS_SENTINEL) begin
            buf_wr_en_s = 1'b1;
            count_d     = count_inc_s;
            if (count_inc_s == RUN_FULL) begin
              state_d   = S_CODE;
              end_pkt_d = in_last;
              tail_d    = 1'b0;
            end else if (in_last) begin
              state_d   = S_CODE;
              end_pkt_d = 1'b1;
              tail_d    = 1'b0;
            end else begin
              state_d = S_FILL;
            end
          end else begin
            // A zero byte closes the block and is implied by the code byte.
            state_d   = S_CODE;
            end_pkt_d = 1'b0;
            tail_d    = in_last;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_CODE: begin
        if (out_ready) begin
          if (count_q != CNT_ZERO) begin
            state_d  = S_DATA;
            rd_idx_d = IDX_ZERO;
          end else if (end_pkt_q) begin
            state_d   = S_FILL;
            end_pkt_d = 1'b0;
          end else if (tail_q) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_CODE;
        end
      end
      S_DATA: begin
        if (out_ready) begin
          if (last_idx_s) begin
            count_d   = CNT_ZERO;
            rd_idx_d  = IDX_ZERO;
            end_pkt_d = 1'b0;
            if (end_pkt_q) begin
              state_d = S_FILL;
            end else if (tail_q) begin
              state_d = S_TAIL;
            end else begin
              state_d = S_FILL;
            end
          end else begin
            rd_idx_d = rd_idx_q + AW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_TAIL: begin
        if (out_ready) begin
          state_d = S_FILL;
          tail_d  = 1'b0;
        end else begin
          state_d = S_TAIL;
        end
      end
      default: begin
        state_d   = S_FILL;
        count_d   = CNT_ZERO;
        rd_idx_d  = IDX_ZERO;
        end_pkt_d = 1'b0;
        tail_d    = 1'b0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = COBS_SENTINEL;
    out_last  = 1'b0;
    case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
      end
      S_CODE: begin
        out_valid = 1'b1;
        out_data  = 8'(count_q) + 8'd1;
        out_last  = (count_q == CNT_ZERO) && end_pkt_q;
      end
      S_DATA: begin
        out_valid = 1'b1;
        out_data  = buf_rd_data_s;
        out_last  = last_idx_s && end_pkt_q;
      end
      S_TAIL: begin
        out_valid = 1'b1;
        out_data  = COBS_TAIL_CODE;
        out_last  = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cobs_encoder.sv
// Directed self-checking bench for cobs_encoder (default MAX_RUN and MAX_RUN=4).
module tb_cobs_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       sel4 = 1'b0;
  logic       manual_ready = 1'b1;
  logic [1:0] bp_mode = 2'd0;
  int         stall_cnt = 0;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_last;
  logic [7:0] a_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_last;
  logic [7:0] b_out_data;
  logic       obs_in_ready, obs_out_valid, obs_out_last;
  logic [7:0] obs_out_data;

  int         n_vec = 0;
  int         n_err = 0;
  int         got_base = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] in_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = 9'h000;

  assign a_in_valid    = in_valid & ~sel4;
  assign b_in_valid    = in_valid & sel4;
  assign obs_in_ready  = sel4 ? b_in_ready  : a_in_ready;
  assign obs_out_valid = sel4 ? b_out_valid : a_out_valid;
  assign obs_out_last  = sel4 ? b_out_last  : a_out_last;
  assign obs_out_data  = sel4 ? b_out_data  : a_out_data;

  cobs_encoder dut (
    .clock(clk), .reset(rst), .in_data(in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_last(in_last), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_last(a_out_last)
  );

  cobs_encoder #(.MAX_RUN(4)) dut4 (
    .clock(clk), .reset(rst), .in_data(in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_last(in_last), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_last(b_out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Downstream ready pattern: always, 10-low/1-high, random, or manual.
  always @(posedge clk) begin
    #2;
    case (bp_mode)
      2'd1: begin
        if (out_ready) begin
          out_ready = 1'b0;
          stall_cnt = 0;
        end else if (stall_cnt >= 9) begin
          out_ready = 1'b1;
        end else begin
          stall_cnt++;
        end
      end
      2'd2: out_ready = 1'($urandom_range(0, 1));
      2'd3: out_ready = manual_ready;
      default: out_ready = 1'b1;
    endcase
  end

  // Output monitor: collect handshakes, check stall stability and input gating.
  always @(negedge clk) begin
    if (!rst && prev_stall) chk("stall_hold", {obs_out_last, obs_out_data}, prev_out);
    if (!rst && in_valid && obs_in_ready) chk("in_while_out", {8'h00, obs_out_valid}, 9'h000);
    if (!rst && obs_out_valid && out_ready) got_q.push_back({obs_out_last, obs_out_data});
    prev_stall = !rst && obs_out_valid && !out_ready;
    prev_out   = {obs_out_last, obs_out_data};
  end

  task automatic send_pkt();
    for (int i = 0; i < in_q.size(); i++) begin
      int waitc;
      waitc    = 0;
      in_data  = in_q[i][7:0];
      in_last  = in_q[i][8];
      in_valid = 1'b1;
      while (obs_in_ready !== 1'b1 && waitc < 300) begin
        @(posedge clk); #1;
        waitc++;
      end
      chk("in_ready_wait", {8'h00, (waitc < 300)}, 9'h001);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    in_q.delete();
  endtask

  task automatic expect_pkt(input string tag);
    int t;
    t = 0;
    while (got_q.size() < got_base + exp_q.size() && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    chk({tag, "_len"}, 9'(got_q.size() - got_base), 9'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [8:0] g;
      g = (got_base + i < got_q.size()) ? got_q[got_base + i] : 9'bx;
      chk($sformatf("%s_b%0d", tag, i), g, exp_q[i]);
    end
    chk({tag, "_idle"}, {8'h00, obs_in_ready}, 9'h001);
    got_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_a_in_ready", {8'h00, a_in_ready}, 9'h001);
    chk("rst_a_out", {a_out_valid, a_out_data}, 9'h000);
    chk("rst_a_last", {8'h00, a_out_last}, 9'h000);
    chk("rst_b_in_ready", {8'h00, b_in_ready}, 9'h001);
    chk("rst_b_out", {b_out_valid, b_out_data}, 9'h000);

    // in_last without in_valid must be ignored
    in_last = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("last_no_valid", {7'h00, obs_out_valid, obs_in_ready}, 9'h001);
    in_last = 1'b0;

    in_q = '{9'h011, 9'h122}; send_pkt();
    exp_q = '{9'h003, 9'h011, 9'h122}; expect_pkt("t1");

    in_q = '{9'h100}; send_pkt();
    exp_q = '{9'h001, 9'h101}; expect_pkt("t2");

    in_q = '{9'h011, 9'h000, 9'h022, 9'h133}; send_pkt();
    exp_q = '{9'h002, 9'h011, 9'h003, 9'h022, 9'h133}; expect_pkt("t3a");

    in_q = '{9'h011, 9'h022, 9'h100}; send_pkt();
    exp_q = '{9'h003, 9'h011, 9'h022, 9'h101}; expect_pkt("t3b");

    sel4 = 1'b1;
    in_q = '{9'h001, 9'h002, 9'h003, 9'h104}; send_pkt();
    exp_q = '{9'h005, 9'h001, 9'h002, 9'h003, 9'h104}; expect_pkt("t4a");
    in_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h105}; send_pkt();
    exp_q = '{9'h005, 9'h001, 9'h002, 9'h003, 9'h004, 9'h002, 9'h105}; expect_pkt("t4b");
    sel4 = 1'b0;

    bp_mode = 2'd1;
    in_q = '{9'h011, 9'h000, 9'h022, 9'h133}; send_pkt();
    exp_q = '{9'h002, 9'h011, 9'h003, 9'h022, 9'h133}; expect_pkt("t5slow");
    bp_mode = 2'd2;
    in_q = '{9'h011, 9'h000, 9'h022, 9'h133}; send_pkt();
    exp_q = '{9'h002, 9'h011, 9'h003, 9'h022, 9'h133}; expect_pkt("t5rand");
    in_q = '{9'h011, 9'h022, 9'h100}; send_pkt();
    exp_q = '{9'h003, 9'h011, 9'h022, 9'h101}; expect_pkt("t5rand_tail");

    // Reset while draining a block
    bp_mode = 2'd3;
    manual_ready = 1'b0;
    @(posedge clk); #1;
    in_q = '{9'h011, 9'h022, 9'h000}; send_pkt();
    manual_ready = 1'b1;
    @(posedge clk); #1;
    manual_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_code", (got_q.size() > got_base) ? got_q[got_base] : 9'bx, 9'h003);
    chk("t6_in_data", {obs_out_valid, obs_out_data}, 9'h111);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_valid", {8'h00, obs_out_valid}, 9'h000);
    chk("t6_rst_ready", {8'h00, obs_in_ready}, 9'h001);
    rst = 1'b0;
    got_base = got_q.size();
    manual_ready = 1'b1;
    @(posedge clk); #1;
    in_q = '{9'h105}; send_pkt();
    exp_q = '{9'h002, 9'h105}; expect_pkt("t6_after");
    bp_mode = 2'd0;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
